// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: source count, irq codes,
// command opcodes and the command-argument decode.
package irq_ctrl_pkg;

    localparam int unsigned NUM_SRC  = 3;
    localparam logic [1:0]  IRQ_NONE = 2'b00;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_CLR = 2'b01,
        OP_DIS = 2'b10,
        OP_ENA = 2'b11
    } op_e;

    // An argument of 0 selects every source; 1..3 selects source arg-1.
    function automatic logic [NUM_SRC-1:0] arg_mask(input logic [1:0] arg);
        logic [NUM_SRC-1:0] m;
        case (arg)
            2'd1:    m = 3'b001;
            2'd2:    m = 3'b010;
            2'd3:    m = 3'b100;
            default: m = '1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Processor-side bus of the interrupt controller: command write strobe/data
// and the status word returned for the readback mux.
interface irq_ctrl_if;

    logic       sel;
    logic       vma;
    logic       rw;
    logic [3:0] datout;
    logic [3:0] stat;

    modport master (
        output sel,
        output vma,
        output rw,
        output datout,
        input  stat
    );

    modport slave (
        input  sel,
        input  vma,
        input  rw,
        input  datout,
        output stat
    );

endinterface

// File: rtl/irq_ctrl_sync.sv
// Per-source synchroniser: SYNC_STAGES flop chain, previous-value flop and
// the pending-set qualifier (rising edge or level).
module irq_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          EDGE_MODE   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic src,
    output logic set
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_depth
        $error("irq_sync: SYNC_STAGES must be 2 or 3");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   s;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], src};
        s      = sync_q[SYNC_STAGES-1];
        prev_d = s;
        set    = EDGE_MODE ? (s & ~prev_q) : s;
    end

    // prev clears with reset, so a source already high at release counts as an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller for procesador: pending/enable registers, bus command
// decode, priority encoder and registered irq/stat outputs.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          EDGE_MODE   = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src,
    irq_ctrl_if.slave          bus,
    output logic [1:0]         irq
);

    logic [NUM_SRC-1:0] set;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] en_q, en_d;
    logic [NUM_SRC-1:0] act;
    logic [NUM_SRC-1:0] mask;
    logic [1:0]         irq_q, irq_d;
    logic [3:0]         stat_q, stat_d;
    logic               cmd;
    op_e                op;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
        irq_sync #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_MODE   (EDGE_MODE)
        ) u_sync (
            .clk   (clk),
            .reset (reset),
            .src   (src[i]),
            .set   (set[i])
        );
    end

    always_comb begin
        cmd    = bus.sel & bus.vma & ~bus.rw;
        op     = op_e'(bus.datout[3:2]);
        mask   = arg_mask(bus.datout[1:0]);
        pend_d = pend_q;
        en_d   = en_q;
        if (cmd) begin
            case (op)
                OP_CLR:  pend_d = pend_q & ~mask;
                OP_DIS:  en_d   = en_q & ~mask;
                OP_ENA:  en_d   = en_q | mask;
                default: ;
            endcase
        end
        // Set is applied after clear so a same-cycle event is never lost.
        pend_d = pend_d | set;

        act = pend_q & en_q;
        if (act[2])      irq_d = 2'd3;
        else if (act[1]) irq_d = 2'd2;
        else if (act[0]) irq_d = 2'd1;
        else             irq_d = IRQ_NONE;
        stat_d = {irq_d != IRQ_NONE, pend_q};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            en_q   <= '0;
            irq_q  <= IRQ_NONE;
            stat_q <= '0;
        end else begin
            pend_q <= pend_d;
            en_q   <= en_d;
            irq_q  <= irq_d;
            stat_q <= stat_d;
        end
    end

    assign irq      = irq_q;
    assign bus.stat = stat_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl (SYNC_STAGES=2, EDGE_MODE=1) with hand-computed
// expectations on irq and stat.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] src;
    logic [1:0] irq;
    int         checks = 0;
    int         errors = 0;

    irq_ctrl_if bif ();

    irq_ctrl #(
        .SYNC_STAGES (2),
        .EDGE_MODE   (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .src   (src),
        .bus   (bif),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bif.sel    = 1'b0;
        bif.vma    = 1'b0;
        bif.rw     = 1'b1;
        bif.datout = 4'h0;
    endtask

    task automatic wr(input logic [3:0] c);
        bif.sel    = 1'b1;
        bif.vma    = 1'b1;
        bif.rw     = 1'b0;
        bif.datout = c;
        step(1);
        idle_bus();
    endtask

    task automatic bad_wr(input logic s, input logic v, input logic r, input logic [3:0] c);
        bif.sel    = s;
        bif.vma    = v;
        bif.rw     = r;
        bif.datout = c;
        step(1);
        idle_bus();
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        src   = 3'b000;
        idle_bus();
        #2;
        check("reset_irq", {2'b00, irq}, 4'h0);
        check("reset_stat", bif.stat, 4'b0000);
        step(1);

        // Test 1: all sources high at release, nothing enabled.
        reset = 1'b1;
        src   = 3'b111;
        step(3);
        check("t1_stat_lag", bif.stat, 4'b0000);
        step(1);
        check("t1_stat_pend", bif.stat, 4'b0111);
        check("t1_irq_masked", {2'b00, irq}, 4'h0);
        src = 3'b000;
        step(3);
        wr(4'b0100);
        step(1);
        check("t1_clr_all", bif.stat, 4'b0000);

        // Test 2: enable all, 3-cycle pulse on src[1].
        wr(4'b1100);
        src = 3'b010;
        step(3);
        src = 3'b000;
        check("t2_irq_early", {2'b00, irq}, 4'h0);
        step(1);
        check("t2_irq_on_time", {2'b00, irq}, 4'd2);
        check("t2_stat", bif.stat, 4'b1010);

        // Test 3: priority and clears.
        src = 3'b001;
        step(3);
        src = 3'b000;
        step(1);
        check("t3_irq_011", {2'b00, irq}, 4'd2);
        check("t3_stat_011", bif.stat, 4'b1011);
        src = 3'b100;
        step(3);
        src = 3'b000;
        step(1);
        check("t3_irq_111", {2'b00, irq}, 4'd3);
        check("t3_stat_111", bif.stat, 4'b1111);
        wr(4'b0111);
        check("t3_clr3_same_edge", {2'b00, irq}, 4'd3);
        step(1);
        check("t3_clr3_irq", {2'b00, irq}, 4'd2);
        check("t3_clr3_stat", bif.stat, 4'b1011);
        wr(4'b0110);
        step(1);
        check("t3_clr2_irq", {2'b00, irq}, 4'd1);
        check("t3_clr2_stat", bif.stat, 4'b1001);

        // Test 4: set edge on src[0] coincides with clear of source 1.
        src = 3'b001;
        step(2);
        wr(4'b0101);
        step(1);
        check("t4_set_wins_irq", {2'b00, irq}, 4'd1);
        check("t4_set_wins_stat", bif.stat, 4'b1001);
        src = 3'b000;
        wr(4'b0101);
        step(1);
        check("t4_clr1_irq", {2'b00, irq}, 4'd0);
        check("t4_clr1_stat", bif.stat, 4'b0000);

        // Test 5: writes without a full strobe are ignored.
        bad_wr(1'b1, 1'b1, 1'b1, 4'b1000);
        bad_wr(1'b1, 1'b0, 1'b0, 4'b1000);
        bad_wr(1'b0, 1'b1, 1'b0, 4'b1000);
        src = 3'b100;
        step(3);
        src = 3'b000;
        step(1);
        check("t5_en_kept", {2'b00, irq}, 4'd3);
        check("t5_en_kept_stat", bif.stat, 4'b1100);
        bad_wr(1'b0, 1'b1, 1'b0, 4'b0100);
        bad_wr(1'b1, 1'b1, 1'b1, 4'b0100);
        bad_wr(1'b1, 1'b0, 1'b0, 4'b0100);
        step(1);
        check("t5_pend_kept", bif.stat, 4'b1100);
        src = 3'b001;
        step(3);
        src = 3'b000;
        step(1);
        check("t5_stat_101", bif.stat, 4'b1101);
        wr(4'b1011);
        step(1);
        check("t5_dis3_irq", {2'b00, irq}, 4'd1);
        check("t5_dis3_stat", bif.stat, 4'b1101);

        // Test 6: asynchronous reset, then a source held high through release.
        wr(4'b1111);
        step(1);
        check("t6_irq_before_rst", {2'b00, irq}, 4'd3);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_irq", {2'b00, irq}, 4'd0);
        check("t6_async_stat", bif.stat, 4'b0000);
        src = 3'b001;
        step(2);
        check("t6_held_in_reset", bif.stat, 4'b0000);
        reset = 1'b1;
        step(3);
        check("t6_rel_lag", bif.stat, 4'b0000);
        step(1);
        check("t6_rel_pend", bif.stat, 4'b0001);
        check("t6_rel_irq_masked", {2'b00, irq}, 4'd0);
        wr(4'b1101);
        step(1);
        check("t6_ena1_irq", {2'b00, irq}, 4'd1);
        wr(4'b0101);
        step(2);
        check("t6_no_reset_level", bif.stat, 4'b0000);
        check("t6_no_reset_irq", {2'b00, irq}, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
